// File: rtl/i2c_fifo_ctrl.sv
// TX/RX FIFO pair for an I2C controller, with occupancy, threshold irqs and sticky error flags.
// Latency: status is visible the cycle after push/pop; read data is one cycle after the pop (FWFT when I2C_FIFO_FWFT_EN is defined).
// Backpressure: none. Pushes into a full FIFO are dropped and set ovf. Pops from an empty FIFO are ignored; on RX they also set rx_udf.

module i2c_fifo_ch #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          dvld,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   ocy
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          push_ok;
    logic          pop_ok;

    assign ocy   = wptr - rptr;
    assign empty = (ocy == '0);
    assign full  = (ocy == (AW+1)'(DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = wr && !flush && (!full || rd);
    assign pop_ok  = rd && !flush && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end

`ifdef I2C_FIFO_FWFT_EN
    assign dout = empty ? '0 : mem[rptr[AW-1:0]];
    assign dvld = !empty;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= '0;
            dvld <= 1'b0;
        end else begin
            dvld <= pop_ok;
            if (pop_ok) dout <= mem[rptr[AW-1:0]];
        end
    end
`endif
endmodule

module i2c_fifo_ctrl #(
    parameter int TX_DW = 10,
    parameter int RX_DW = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tx_wr,
    input  logic [TX_DW-1:0] tx_din,
    input  logic             tx_rd,
    output logic [TX_DW-1:0] tx_dout,
    output logic             tx_empty,
    output logic             tx_full,
    output logic [AW:0]      tx_ocy,
    input  logic             rx_wr,
    input  logic [RX_DW-1:0] rx_din,
    input  logic             rx_rd,
    output logic [RX_DW-1:0] rx_dout,
    output logic             rx_empty,
    output logic             rx_full,
    output logic [AW:0]      rx_ocy,
    input  logic             tx_flush,
    input  logic             rx_flush,
    input  logic [AW:0]      tx_thr,
    input  logic [AW:0]      rx_thr,
    output logic             irq_tx_low,
    output logic             irq_rx_thr,
    output logic             tx_ovf,
    output logic             rx_ovf,
    output logic             rx_udf,
    input  logic             err_clr,
    output logic             tx_dvld,
    output logic             rx_dvld
);
    logic tx_ovf_set;
    logic rx_ovf_set;
    logic rx_udf_set;

    i2c_fifo_ch #(.DW(TX_DW), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rstn(rstn), .flush(tx_flush),
        .wr(tx_wr), .din(tx_din), .rd(tx_rd),
        .dout(tx_dout), .dvld(tx_dvld),
        .empty(tx_empty), .full(tx_full), .ocy(tx_ocy)
    );

    i2c_fifo_ch #(.DW(RX_DW), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rstn(rstn), .flush(rx_flush),
        .wr(rx_wr), .din(rx_din), .rd(rx_rd),
        .dout(rx_dout), .dvld(rx_dvld),
        .empty(rx_empty), .full(rx_full), .ocy(rx_ocy)
    );

    // Flush swallows a same-cycle push or pop without flagging an error.
    assign tx_ovf_set = tx_wr && tx_full && !tx_rd && !tx_flush;
    assign rx_ovf_set = rx_wr && rx_full && !rx_rd && !rx_flush;
    assign rx_udf_set = rx_rd && rx_empty && !rx_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ovf     <= 1'b0;
            rx_ovf     <= 1'b0;
            rx_udf     <= 1'b0;
            irq_tx_low <= 1'b0;
            irq_rx_thr <= 1'b0;
        end else begin
            tx_ovf     <= tx_ovf_set || (tx_ovf && !err_clr);
            rx_ovf     <= rx_ovf_set || (rx_ovf && !err_clr);
            rx_udf     <= rx_udf_set || (rx_udf && !err_clr);
            irq_tx_low <= (tx_ocy <= tx_thr);
            irq_rx_thr <= (rx_ocy >= rx_thr) && (rx_thr != '0);
        end
    end
endmodule

// File: tb/tb_i2c_fifo_ctrl.sv
// Directed bench for i2c_fifo_ctrl: pops queue expected words, a negedge monitor checks read data.
module tb_i2c_fifo_ctrl;
    localparam int TX_DW = 10;
    localparam int RX_DW = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             tx_wr, tx_rd, rx_wr, rx_rd;
    logic [TX_DW-1:0] tx_din, tx_dout;
    logic [RX_DW-1:0] rx_din, rx_dout;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic [AW:0]      tx_ocy, rx_ocy, tx_thr, rx_thr;
    logic             tx_flush, rx_flush, err_clr;
    logic             irq_tx_low, irq_rx_thr, tx_ovf, rx_ovf, rx_udf;
    logic             tx_dvld, rx_dvld;

    int checks = 0;
    int errors = 0;
    logic [TX_DW-1:0] tx_q[$];
    logic [RX_DW-1:0] rx_q[$];

    i2c_fifo_ctrl #(.TX_DW(TX_DW), .RX_DW(RX_DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .tx_wr(tx_wr), .tx_din(tx_din), .tx_rd(tx_rd), .tx_dout(tx_dout),
        .tx_empty(tx_empty), .tx_full(tx_full), .tx_ocy(tx_ocy),
        .rx_wr(rx_wr), .rx_din(rx_din), .rx_rd(rx_rd), .rx_dout(rx_dout),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_ocy(rx_ocy),
        .tx_flush(tx_flush), .rx_flush(rx_flush),
        .tx_thr(tx_thr), .rx_thr(rx_thr),
        .irq_tx_low(irq_tx_low), .irq_rx_thr(irq_rx_thr),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .rx_udf(rx_udf),
        .err_clr(err_clr), .tx_dvld(tx_dvld), .rx_dvld(rx_dvld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_wr = 0; tx_rd = 0; rx_wr = 0; rx_rd = 0;
        tx_flush = 0; rx_flush = 0; err_clr = 0;
    endtask

`ifdef I2C_FIFO_FWFT_EN
    wire tx_fire = tx_rd && tx_dvld;
    wire rx_fire = rx_rd && rx_dvld;
`else
    wire tx_fire = tx_dvld;
    wire rx_fire = rx_dvld;
`endif

    always @(negedge clk) begin
        if (rstn && tx_fire) begin
            if (tx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_data: got 0x%0h with nothing expected", tx_dout);
            end else chk("tx_data", 32'(tx_dout), 32'(tx_q.pop_front()));
        end
        if (rstn && rx_fire) begin
            if (rx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_data: got 0x%0h with nothing expected", rx_dout);
            end else chk("rx_data", 32'(rx_dout), 32'(rx_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rstn = 0; tx_din = '0; rx_din = '0; tx_thr = 5'd2; rx_thr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_ocy", 32'(tx_ocy), 0);
        chk("rst_tx_empty", 32'(tx_empty), 1);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_tx_dout", 32'(tx_dout), 0);
        chk("rst_rx_dout", 32'(rx_dout), 0);
        chk("rst_flags", {27'd0, tx_ovf, rx_ovf, rx_udf, irq_tx_low, irq_rx_thr}, 0);
        chk("rst_dvld", {30'd0, tx_dvld, rx_dvld}, 0);
        rstn = 1;
        tick();

        // Fill TX, overflow with 0x3FF, drain in order.
        for (int i = 0; i < 16; i++) begin
            tx_wr = 1; tx_din = 10'(i); tick();
        end
        tx_din = 10'h3FF; tick();
        idle(); tick();
        chk("tx_full", 32'(tx_full), 1);
        chk("tx_ocy_full", 32'(tx_ocy), 16);
        chk("tx_ovf_set", 32'(tx_ovf), 1);
        chk("irq_tx_low_full", 32'(irq_tx_low), 0);
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(10'(i)); tx_rd = 1; tick();
        end
        idle(); tick(); tick();
        chk("tx_empty_drained", 32'(tx_empty), 1);
        chk("irq_tx_low_empty", 32'(irq_tx_low), 1);
        err_clr = 1; tick(); idle();
        chk("tx_ovf_clr", 32'(tx_ovf), 0);

        // Registered-read timing of a single 0x55 pop.
        tx_wr = 1; tx_din = 10'h055; tick(); idle();
`ifdef I2C_FIFO_FWFT_EN
        chk("fwft_dout", 32'(tx_dout), 32'h55);
        chk("fwft_dvld", 32'(tx_dvld), 1);
        tx_q.push_back(10'h055); tx_rd = 1; tick(); idle();
        chk("fwft_dvld_after", 32'(tx_dvld), 0);
`else
        chk("reg_dvld_before", 32'(tx_dvld), 0);
        tx_q.push_back(10'h055); tx_rd = 1; tick(); idle();
        chk("reg_dout_55", 32'(tx_dout), 32'h55);
        chk("reg_dvld_55", 32'(tx_dvld), 1);
        tick();
        chk("reg_dvld_pulse", 32'(tx_dvld), 0);
        chk("reg_dout_hold", 32'(tx_dout), 32'h55);
`endif

        // RX full with simultaneous push and pop; rx_thr=0 keeps irq low.
        for (int i = 0; i < 16; i++) begin
            rx_wr = 1; rx_din = 8'(8'hA0 + i); tick();
        end
        idle(); tick();
        chk("rx_full", 32'(rx_full), 1);
        chk("irq_rx_thr_zero", 32'(irq_rx_thr), 0);
        rx_wr = 1; rx_din = 8'h77; rx_rd = 1; rx_q.push_back(8'hA0); tick(); idle();
        chk("rx_ocy_full_rw", 32'(rx_ocy), 16);
        chk("rx_ovf_full_rw", 32'(rx_ovf), 0);
        for (int i = 1; i < 16; i++) begin
            rx_q.push_back(8'(8'hA0 + i)); rx_rd = 1; tick();
        end
        rx_q.push_back(8'h77); rx_rd = 1; tick(); idle(); tick();
        chk("rx_empty_drained", 32'(rx_empty), 1);

        // Underflow, then err_clr coincident with a second underflow.
        rx_rd = 1; tick(); idle();
        chk("rx_udf_first", 32'(rx_udf), 1);
        chk("rx_ocy_udf", 32'(rx_ocy), 0);
        rx_rd = 1; err_clr = 1; tick(); idle();
        chk("rx_udf_set_wins", 32'(rx_udf), 1);
        err_clr = 1; tick(); idle();
        chk("rx_udf_clr", 32'(rx_udf), 0);

        // Push and pop together while empty.
        rx_wr = 1; rx_din = 8'h3C; rx_rd = 1; tick(); idle();
        chk("rx_ocy_empty_rw", 32'(rx_ocy), 1);
        chk("rx_udf_empty_rw", 32'(rx_udf), 1);
        rx_q.push_back(8'h3C); rx_rd = 1; err_clr = 1; tick(); idle(); tick();

        // Threshold interrupt at 4 words.
        rx_thr = 5'd4;
        for (int i = 0; i < 4; i++) begin
            rx_wr = 1; rx_din = 8'(8'h11 + i); tick();
        end
        idle(); tick();
        chk("irq_rx_thr_4", 32'(irq_rx_thr), 1);
        rx_thr = 5'd0; tick();
        chk("irq_rx_thr_off", 32'(irq_rx_thr), 0);
        for (int i = 0; i < 4; i++) begin
            rx_q.push_back(8'(8'h11 + i)); rx_rd = 1; tick();
        end
        idle(); tick();

        // Flush dominates a push; then a pointer-wrapping stream.
        for (int i = 0; i < 10; i++) begin
            tx_wr = 1; tx_din = 10'(10'h100 + i); tick();
        end
        tx_flush = 1; tx_wr = 1; tx_din = 10'h2AA; tick(); idle();
        chk("flush_ocy", 32'(tx_ocy), 0);
        chk("flush_empty", 32'(tx_empty), 1);
        chk("flush_ovf", 32'(tx_ovf), 0);
        for (int j = 0; j < 3; j++) begin
            tx_wr = 1; tx_din = 10'(10'h200 + j); tick();
        end
        for (int j = 0; j < 40; j++) begin
            tx_wr = 1; tx_din = 10'(10'h200 + j + 3);
            tx_rd = 1; tx_q.push_back(10'(10'h200 + j)); tick();
            if (j == 20) begin
                chk("wrap_ocy", 32'(tx_ocy), 3);
                chk("wrap_irq_tx_low", 32'(irq_tx_low), 0);
            end
        end
        tx_wr = 0;
        for (int j = 40; j < 43; j++) begin
            tx_q.push_back(10'(10'h200 + j)); tx_rd = 1; tick();
        end
        idle(); tick(); tick();
        chk("wrap_drained", 32'(tx_ocy), 0);

        // Reset mid-operation discards RX contents at once.
        rx_wr = 1; rx_din = 8'h99; tick(); tick(); idle();
        rstn = 0; #2;
        chk("midrst_rx_ocy", 32'(rx_ocy), 0);
        chk("midrst_rx_empty", 32'(rx_empty), 1);
        tick(); rstn = 1; tick(); tick();

        chk("tx_q_left", tx_q.size(), 0);
        chk("rx_q_left", rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
